// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and widths for the I2C target.
//   i2c_state_e : byte-level protocol state
//   I2C_ADDR_W  : 7-bit bus address width
//   I2C_BYTE_W  : data byte width
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_ADDR, WRITE, ACK_WRITE, READ, ACK_READ
  } i2c_state_e;
endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: 2-FF synchronizer plus a previous-cycle copy for edge strobes.
//   clk_i, rst_i : system clock, synchronous active-high reset (flops reset to 1 = bus idle)
//   d_i          : asynchronous bus line
//   q_o          : synchronized level
//   rise_o/fall_o: one-cycle strobes on synchronized transitions
module i2c_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic r_meta, r_sync, r_prev;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign q_o    = r_sync;
  assign rise_o =  r_sync & ~r_prev;
  assign fall_o = ~r_sync &  r_prev;
endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C target (slave) with one 7-bit address, byte write/read, no clock stretching.
//   clk_i, rst_i : system clock (>=16x SCL), synchronous active-high reset
//   scl_i        : bus clock (input only)
//   sda_io       : open-drain data, driven 0 or Z
//   tx_data_i    : next read byte, consumed when rd_req_o pulses
//   rd_req_o     : pulse, tx_data_i latched
//   rx_data_o    : last written byte; rx_valid_o pulses when it updates
//   nack_o       : pulse, master NACKed a read byte
//   busy_o       : addressed, until STOP or next START
//   rw_o         : R/W bit of the last matched address (1 = read)
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h42
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  scl_i,
  inout  wire                   sda_io,
  input  logic [I2C_BYTE_W-1:0] tx_data_i,
  output logic                  rd_req_o,
  output logic [I2C_BYTE_W-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  nack_o,
  output logic                  busy_o,
  output logic                  rw_o
);
  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;
  logic [I2C_BYTE_W-1:0] w_shift;

  i2c_sync_edge u_scl (.clk_i(clk_i), .rst_i(rst_i), .d_i(scl_i),
                       .q_o(w_scl), .rise_o(w_scl_rise), .fall_o(w_scl_fall));
  i2c_sync_edge u_sda (.clk_i(clk_i), .rst_i(rst_i), .d_i(sda_io),
                       .q_o(w_sda), .rise_o(w_sda_rise), .fall_o(w_sda_fall));

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;

  i2c_state_e            r_state;
  logic [I2C_BYTE_W-1:0] r_shreg;
  logic [2:0]            r_bitcnt;
  logic                  r_ack_ph;   // ACK_*: second half of the ACK slot
  logic                  r_sda_oe;

  assign w_shift = {r_shreg[I2C_BYTE_W-2:0], w_sda};
  assign sda_io  = r_sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_bitcnt   <= '0;
      r_ack_ph   <= 1'b0;
      r_sda_oe   <= 1'b0;
      rx_data_o  <= '0;
      rw_o       <= 1'b0;
      busy_o     <= 1'b0;
      rd_req_o   <= 1'b0;
      rx_valid_o <= 1'b0;
      nack_o     <= 1'b0;
    end else begin
      rd_req_o   <= 1'b0;
      rx_valid_o <= 1'b0;
      nack_o     <= 1'b0;
      // Bus conditions override any SCL edge in the same cycle.
      if (w_start) begin
        r_state  <= ADDR;
        r_bitcnt <= '0;
        r_ack_ph <= 1'b0;
        r_sda_oe <= 1'b0;
        busy_o   <= 1'b0;
      end else if (w_stop) begin
        r_state  <= IDLE;
        r_sda_oe <= 1'b0;
        busy_o   <= 1'b0;
      end else begin
        case (r_state)
          ADDR: if (w_scl_rise) begin
            r_shreg  <= w_shift;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              if (w_shift[7:1] == TARGET_ADDR) begin
                r_state  <= ACK_ADDR;
                rw_o     <= w_sda;
                busy_o   <= 1'b1;
                r_ack_ph <= 1'b0;
              end else begin
                r_state <= IDLE;
              end
            end
          end
          ACK_ADDR, ACK_WRITE: if (w_scl_fall) begin
            if (!r_ack_ph) begin
              r_sda_oe <= 1'b1;
              r_ack_ph <= 1'b1;
            end else begin
              r_ack_ph <= 1'b0;
              r_bitcnt <= '0;
              if (r_state == ACK_ADDR && rw_o) begin
                // ACK release and first read bit share this SCL low phase.
                r_state  <= READ;
                r_shreg  <= tx_data_i;
                rd_req_o <= 1'b1;
                r_sda_oe <= ~tx_data_i[7];
              end else begin
                r_state  <= WRITE;
                r_sda_oe <= 1'b0;
              end
            end
          end
          WRITE: if (w_scl_rise) begin
            r_shreg  <= w_shift;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              rx_data_o  <= w_shift;
              rx_valid_o <= 1'b1;
              r_state    <= ACK_WRITE;
              r_ack_ph   <= 1'b0;
            end
          end
          READ: if (w_scl_fall) begin
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_sda_oe <= 1'b0;
              r_state  <= ACK_READ;
              r_ack_ph <= 1'b0;
            end else begin
              r_shreg  <= r_shreg << 1;
              r_sda_oe <= ~r_shreg[6];
            end
          end
          ACK_READ: begin
            if (w_scl_rise && !r_ack_ph) begin
              if (w_sda) begin
                nack_o   <= 1'b1;
                r_state  <= IDLE;
                r_sda_oe <= 1'b0;
              end else begin
                r_ack_ph <= 1'b1;
              end
            end else if (w_scl_fall && r_ack_ph) begin
              r_ack_ph <= 1'b0;
              r_bitcnt <= '0;
              r_state  <= READ;
              r_shreg  <= tx_data_i;
              rd_req_o <= 1'b1;
              r_sda_oe <= ~tx_data_i[7];
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bit-banged I2C master against i2c_target.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int Q = 20;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_oe = 1'b0;
  logic [7:0] tx = 8'h00;
  wire        sda;
  logic       rd_req, rx_valid, nack, busy, rw;
  logic [7:0] rx_data;

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

  i2c_target #(.TARGET_ADDR(7'h42)) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl), .sda_io(sda), .tx_data_i(tx),
    .rd_req_o(rd_req), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .nack_o(nack), .busy_o(busy), .rw_o(rw)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int n_rd = 0, n_rxv = 0, n_nack = 0;

  always @(negedge clk) begin
    if (rd_req)   n_rd++;
    if (rx_valid) n_rxv++;
    if (nack)     n_nack++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic waitc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period; b=1 releases SDA. Returns SDA sampled mid-high.
  task automatic bit_x(input logic b, output logic s);
    m_oe = ~b;
    waitc(Q); scl = 1'b1;
    waitc(Q); s = sda;
    waitc(Q); scl = 1'b0;
    waitc(Q);
  endtask

  task automatic i2c_start();
    m_oe = 1'b0; waitc(Q);
    scl = 1'b1;  waitc(Q);
    m_oe = 1'b1; waitc(Q);
    scl = 1'b0;  waitc(Q);
  endtask

  task automatic i2c_stop();
    m_oe = 1'b1; waitc(Q);
    scl = 1'b1;  waitc(Q);
    m_oe = 1'b0; waitc(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_x(d[i], s);
    bit_x(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, s);
      d[i] = s;
    end
    bit_x(~mack, s);
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] d;
    int         b_rd, b_rxv, b_nack;

    // Reset state
    waitc(4);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_rw", 32'(rw), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pulses", 32'({rd_req, rx_valid, nack}), 32'h0);
    chk("rst_sda", 32'(sda), 32'h1);
    rst = 1'b0;
    waitc(4);

    // Write 0xA5 to 0x42
    b_rxv = n_rxv;
    i2c_start();
    wr_byte(8'h84, ack);
    chk("w_addr_ack", 32'(ack), 32'h1);
    chk("w_busy", 32'(busy), 32'h1);
    chk("w_rw", 32'(rw), 32'h0);
    wr_byte(8'hA5, ack);
    chk("w_data_ack", 32'(ack), 32'h1);
    i2c_stop();
    chk("w_rxv_cnt", 32'(n_rxv - b_rxv), 32'd1);
    chk("w_rx_data", 32'(rx_data), 32'hA5);
    chk("w_busy_stop", 32'(busy), 32'h0);

    // Read two bytes, ACK then NACK
    b_rd = n_rd; b_nack = n_nack;
    tx = 8'h3C;
    i2c_start();
    wr_byte(8'h85, ack);
    chk("r_addr_ack", 32'(ack), 32'h1);
    chk("r_rw", 32'(rw), 32'h1);
    tx = 8'h7E;
    rd_byte(1'b1, d);
    chk("r_byte1", 32'(d), 32'h3C);
    rd_byte(1'b0, d);
    chk("r_byte2", 32'(d), 32'h7E);
    i2c_stop();
    chk("r_rd_cnt", 32'(n_rd - b_rd), 32'd2);
    chk("r_nack_cnt", 32'(n_nack - b_nack), 32'd1);

    // Wrong address 0x48
    b_rxv = n_rxv;
    i2c_start();
    wr_byte(8'h90, ack);
    chk("x_addr_nack", 32'(ack), 32'h0);
    chk("x_busy", 32'(busy), 32'h0);
    wr_byte(8'hFF, ack);
    i2c_stop();
    chk("x_rxv_cnt", 32'(n_rxv - b_rxv), 32'd0);

    // Write 0x11, repeated START, read one byte
    i2c_start();
    wr_byte(8'h84, ack);
    wr_byte(8'h11, ack);
    chk("rs_rx_data", 32'(rx_data), 32'h11);
    chk("rs_rw0", 32'(rw), 32'h0);
    tx = 8'h5A;
    i2c_start();
    wr_byte(8'h85, ack);
    chk("rs_addr_ack", 32'(ack), 32'h1);
    chk("rs_rw1", 32'(rw), 32'h1);
    rd_byte(1'b0, d);
    chk("rs_byte", 32'(d), 32'h5A);
    i2c_stop();

    // Reset during bit 4 of a read byte (all-zero byte keeps SDA driven low)
    tx = 8'h00;
    i2c_start();
    wr_byte(8'h85, ack);
    for (int i = 0; i < 3; i++) bit_x(1'b1, s);
    m_oe = 1'b0;
    waitc(Q); scl = 1'b1;
    waitc(Q / 2);
    chk("rr_sda_driven", 32'(sda), 32'h0);
    b_rd = n_rd;
    rst = 1'b1;
    waitc(1);
    rst = 1'b0;
    chk("rr_sda_released", 32'(sda), 32'h1);
    chk("rr_busy", 32'(busy), 32'h0);
    waitc(Q); scl = 1'b0; waitc(Q);
    for (int i = 0; i < 5; i++) bit_x(1'b1, s);
    chk("rr_rd_cnt", 32'(n_rd - b_rd), 32'd0);
    m_oe = 1'b0; waitc(Q); scl = 1'b1; waitc(Q);
    i2c_start();
    wr_byte(8'h84, ack);
    chk("rr_addr_ack", 32'(ack), 32'h1);
    i2c_stop();

    // STOP after 3 data bits of a write
    b_rxv = n_rxv;
    i2c_start();
    wr_byte(8'h84, ack);
    bit_x(1'b1, s); bit_x(1'b0, s); bit_x(1'b1, s);
    i2c_stop();
    waitc(4);
    chk("ab_rxv_cnt", 32'(n_rxv - b_rxv), 32'd0);
    chk("ab_state", 32'(dut.r_state), 32'(IDLE));
    chk("ab_busy", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
